// File: rtl/seq_alu.sv
// Multi-cycle ALU with START/BUSY/DONE handshake: single-cycle logic ops,
// iterative shift-add multiply and bit-serial shifts, full ZNCV flag set.
module seq_alu #(
   parameter int unsigned WIDTH  = 8,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             NEG,
   output logic             CARRY,
   output logic             OVF,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned PW  = 2 * WIDTH;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t           state_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    mcand_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, neg_q, carry_q, ovf_q, busy_q, done_q, err_q;

   logic [SHW-1:0]   amt;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_v, sc_err, sc_multi;
   logic [PW-1:0]    acc_nx;
   logic [WIDTH-1:0] work_nx, fin_res;
   logic             work_out, fin_c, fin_v;

   assign amt  = DATA2[SHW-1:0];
   assign sum  = {1'b0, DATA1} + {1'b0, DATA2};
   assign diff = {1'b0, DATA1} - {1'b0, DATA2};

   // Result and flags for ops that complete at the accepting edge
   always_comb begin : single_cycle
      sc_res   = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      sc_err   = 1'b0;
      sc_multi = 1'b0;
      case (SELECT)
         3'b000: sc_res = DATA2;
         3'b001: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum[WIDTH-1] != DATA1[WIDTH-1]);
         end
         3'b010: sc_res = DATA1 & DATA2;
         3'b011: sc_res = DATA1 | DATA2;
         3'b100: begin
            sc_res = diff[WIDTH-1:0];
            sc_c   = ~diff[WIDTH];
            sc_v   = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (diff[WIDTH-1] != DATA1[WIDTH-1]);
         end
         3'b101: begin
            if (MUL_EN) sc_multi = 1'b1;
            else        sc_err   = 1'b1;
         end
         default: begin
            if (amt != '0) sc_multi = 1'b1;
            else           sc_res   = DATA1;
         end
      endcase
   end

   // One iteration of the running op, plus the values committed on its last step
   always_comb begin : iterate
      acc_nx   = acc_q + (work_q[0] ? mcand_q : '0);
      work_nx  = {work_q[WIDTH-2:0], 1'b0};
      work_out = work_q[WIDTH-1];
      if (op_q == 3'b111) begin
         work_nx  = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         work_out = work_q[0];
      end
      fin_res = work_nx;
      fin_c   = work_out;
      fin_v   = 1'b0;
      if (op_q == 3'b101) begin
         fin_res = acc_nx[WIDTH-1:0];
         fin_c   = |acc_nx[PW-1:WIDTH];
         fin_v   = fin_c;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         work_q   <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  if (sc_multi) begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b1;
                     op_q    <= SELECT;
                     acc_q   <= '0;
                     mcand_q <= PW'(DATA1);
                     if (SELECT == 3'b101) begin
                        cnt_q  <= CW'(WIDTH);
                        work_q <= DATA2;
                     end else begin
                        cnt_q  <= CW'(amt);
                        work_q <= DATA1;
                     end
                  end else begin
                     result_q <= sc_res;
                     zero_q   <= (sc_res == '0);
                     neg_q    <= sc_res[WIDTH-1];
                     carry_q  <= sc_c;
                     ovf_q    <= sc_v;
                     done_q   <= 1'b1;
                     err_q    <= sc_err;
                  end
               end
            end
            S_RUN: begin
               cnt_q   <= cnt_q - CW'(1);
               acc_q   <= acc_nx;
               mcand_q <= mcand_q << 1;
               work_q  <= (op_q == 3'b101) ? (work_q >> 1) : work_nx;
               if (cnt_q == CW'(1)) begin
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  result_q <= fin_res;
                  zero_q   <= (fin_res == '0);
                  neg_q    <= fin_res[WIDTH-1];
                  carry_q  <= fin_c;
                  ovf_q    <= fin_v;
                  done_q   <= 1'b1;
               end
            end
         endcase
      end
   end

   assign RESULT = result_q;
   assign ZERO   = zero_q;
   assign NEG    = neg_q;
   assign CARRY  = carry_q;
   assign OVF    = ovf_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign ERR    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed and random ops against an arithmetic reference model.
module tb_seq_alu;
   localparam int W = 8;

   logic         CLK, RESET, START, START0;
   logic [2:0]   SELECT;
   logic [W-1:0] DATA1, DATA2;
   logic [W-1:0] RESULT, RESULT0;
   logic         ZERO, NEG, CARRY, OVF, BUSY, DONE, ERR;
   logic         ZERO0, NEG0, CARRY0, OVF0, BUSY0, DONE0, ERR0;

   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
      .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO), .NEG(NEG),
      .CARRY(CARRY), .OVF(OVF), .BUSY(BUSY), .DONE(DONE), .ERR(ERR));

   seq_alu #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
      .CLK(CLK), .RESET(RESET), .START(START0), .SELECT(SELECT),
      .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT0), .ZERO(ZERO0), .NEG(NEG0),
      .CARRY(CARRY0), .OVF(OVF0), .BUSY(BUSY0), .DONE(DONE0), .ERR(ERR0));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: results from integer arithmetic; lat = edges after the accepting edge until DONE
   function automatic void model(input int op, input int a, input int b, input bit mul_en,
                                 output int res, output bit z, output bit n, output bit c,
                                 output bit v, output bit err, output int lat);
      int sa, sb, t, s;
      res = 0; c = 1'b0; v = 1'b0; err = 1'b0; lat = 0;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      s  = b % W;
      case (op)
         0: res = b;
         1: begin t = a + b; res = t % 256; c = (t >= 256); v = (sa + sb > 127) || (sa + sb < -128); end
         2: res = a & b;
         3: res = a | b;
         4: begin t = a - b; res = (t + 256) % 256; c = (a >= b); v = (sa - sb > 127) || (sa - sb < -128); end
         5: begin
            if (mul_en) begin t = a * b; res = t % 256; c = (t / 256) != 0; v = c; lat = W; end
            else err = 1'b1;
         end
         6: begin res = (a << s) % 256; c = (s != 0) && (((a >> (W - s)) & 1) != 0); lat = s; end
         default: begin res = (sa >>> s) & 255; c = (s != 0) && (((a >> (s - 1)) & 1) != 0); lat = s; end
      endcase
      z = (res == 0);
      n = (res >= 128);
   endfunction

   // Issue one op on dut, optionally hammering the inputs while it runs, and check it
   task automatic run_op(input int op, input int a, input int b, input bit disturb);
      int e_res, e_lat, edges;
      bit e_z, e_n, e_c, e_v, e_err;
      model(op, a, b, 1'b1, e_res, e_z, e_n, e_c, e_v, e_err, e_lat);
      SELECT = 3'(op); DATA1 = 8'(a); DATA2 = 8'(b); START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("busy_after_start", {31'b0, BUSY}, {31'b0, (e_lat > 0)});
      edges = 0;
      while (DONE !== 1'b1 && edges < 2 * W) begin
         if (disturb) begin
            START = 1'b1; SELECT = 3'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom);
         end
         @(posedge CLK); #1;
         edges++;
      end
      START = 1'b0;
      chk("latency", edges, e_lat);
      chk("result", {24'b0, RESULT}, e_res);
      chk("zero", {31'b0, ZERO}, {31'b0, e_z});
      chk("neg", {31'b0, NEG}, {31'b0, e_n});
      chk("carry", {31'b0, CARRY}, {31'b0, e_c});
      chk("ovf", {31'b0, OVF}, {31'b0, e_v});
      chk("err", {31'b0, ERR}, {31'b0, e_err});
      chk("busy_at_done", {31'b0, BUSY}, 0);
      @(posedge CLK); #1;
      chk("done_fall", {31'b0, DONE}, 0);
      chk("result_held", {24'b0, RESULT}, e_res);
   endtask

   initial begin
      RESET = 1'b0; START = 1'b0; START0 = 1'b0;
      SELECT = '0; DATA1 = '0; DATA2 = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_outputs", {ERR, DONE, BUSY, OVF, CARRY, NEG, ZERO, RESULT}, 0);
      chk("rst_outputs0", {ERR0, DONE0, BUSY0, OVF0, CARRY0, NEG0, ZERO0, RESULT0}, 0);
      RESET = 1'b1;
      @(posedge CLK); #1;

      // Directed cases
      run_op(1, 8'h7F, 8'h01, 1'b0);
      run_op(5, 8'h10, 8'h11, 1'b1);
      run_op(7, 8'h80, 3, 1'b0);
      run_op(6, 8'h81, 1, 1'b0);
      run_op(6, 8'h81, 0, 1'b0);

      // Back-to-back SUB in the DONE cycle
      SELECT = 3'd4; DATA1 = 8'h05; DATA2 = 8'h05; START = 1'b1;
      @(posedge CLK); #1;
      chk("b2b_done1", {31'b0, DONE}, 1);
      chk("b2b_res1", {ZERO, CARRY, NEG, RESULT}, {21'b0, 3'b110, 8'h00});
      DATA1 = 8'h03; DATA2 = 8'h05;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("b2b_done2", {31'b0, DONE}, 1);
      chk("b2b_res2", {ZERO, CARRY, NEG, RESULT}, {21'b0, 3'b001, 8'hFE});
      @(posedge CLK); #1;
      chk("b2b_done_fall", {31'b0, DONE}, 0);

      // Asynchronous reset in the middle of a multiply
      SELECT = 3'd5; DATA1 = 8'h0F; DATA2 = 8'hFF; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (4) @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      chk("async_rst", {ERR, DONE, BUSY, OVF, CARRY, NEG, ZERO, RESULT}, 0);
      @(posedge CLK); #1;
      RESET = 1'b1;
      for (int k = 0; k < W + 2; k++) begin
         @(posedge CLK); #1;
         chk("no_done_after_abort", {30'b0, DONE, BUSY}, 0);
      end
      run_op(5, 8'h03, 8'h04, 1'b0);

      // Illegal opcode on the MUL-less build
      SELECT = 3'd5; DATA1 = 8'h12; DATA2 = 8'h34; START0 = 1'b1;
      @(posedge CLK); #1;
      START0 = 1'b0;
      chk("illegal_pulse", {30'b0, ERR0, DONE0}, 3);
      chk("illegal_flags", {BUSY0, OVF0, CARRY0, NEG0, ZERO0, RESULT0}, {19'b0, 5'b00001, 8'h00});
      @(posedge CLK); #1;
      chk("illegal_pulse_fall", {30'b0, ERR0, DONE0}, 0);
      SELECT = 3'd1; DATA1 = 8'h20; DATA2 = 8'h22; START0 = 1'b1;
      @(posedge CLK); #1;
      START0 = 1'b0;
      chk("nomul_add", {ERR0, DONE0, RESULT0}, {22'b0, 2'b01, 8'h42});

      // Random ops
      for (int i = 0; i < 40; i++) begin
         int op, a, b;
         op = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         run_op(op, a, b, i[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
